traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Independent checker on the lights interface. It samples main_lights and cross_lights as they leave the traffic FSM and checks them against the signalling rules.
- It flags the first violation with a sticky fault and a 4-bit fault code. The code feeds the seven_seg_decoder for display.
- It sits beside the traffic FSM in the top level, on the same clk, with no feedback into the FSM.

Parameters:
- TICK_COUNT, 49999999, clk cycles per 1 s tick minus one (benches use 4).
- MIN_YELLOW, 3, minimum whole ticks a yellow or yellow_arrow must be held before red.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- main_lights  input  5  {red,yellow,green,yellow_arrow,green_arrow}, bit4 = red; synchronous to clk.
- cross_lights  input  5  same encoding as main_lights.
- clear  input  1  synchronous; clears the sticky fault.
- fault  output  1  sticky violation flag.
- fault_code  output  4  code of the first captured violation; 0 = none.
- tick  output  1  one-cycle pulse every TICK_COUNT+1 cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - fault=0, fault_code=0, tick=0, prescaler=TICK_COUNT.
  - prev_main=prev_cross=5'b10000 (red).
  - Both yellow-second counters = 0.
- Prescaler:
  - Decrements every clk.
  - At 0 it reloads TICK_COUNT and pulses tick for exactly one cycle.
- Per-approach yellow counter, 4 bits, saturating at 15:
  - Cleared on the cycle the approach enters yellow or yellow_arrow.
  - Otherwise increments on tick while the light is yellow or yellow_arrow.
- Each cycle the inputs are sampled and compared against prev_*. prev_* then update to the sampled values, even while a fault is held.
- Violation codes, evaluated in parallel:
  - 1: main_lights not one-hot (zero bits or more than one bit set).
  - 2: cross_lights not one-hot.
  - 3: conflict, both approaches simultaneously non-red.
  - 4: illegal main transition.
  - 5: illegal cross transition.
  - 6: main yellow/yellow_arrow went to red with counter < MIN_YELLOW.
  - 7: cross yellow/yellow_arrow went to red with counter < MIN_YELLOW.
- Legal transitions:
  - Holding the same light.
  - red->green and red->green_arrow.
  - green->yellow, yellow->red.
  - green_arrow->yellow_arrow, yellow_arrow->red.
  - Every other change between one-hot values is illegal (e.g. green->red, yellow->green, red->yellow, green->green_arrow).
- Transition and timing checks (codes 4-7) apply only when both the previous and current values of that approach are one-hot. A non-one-hot sample raises code 1/2 only.
- Capture:
  - If fault=0 and any violation is present, then on the next clk edge fault=1 and fault_code = lowest active code.
  - Latency is one cycle from the offending sample.
  - While fault=1, fault_code is frozen; later violations are ignored.
- Clear:
  - clear=1 with no violation present: fault=0 and fault_code=0 next cycle.
  - clear=1 in the same cycle as a violation: the new violation is captured (fault stays 1, code updated).
- Reset mid-operation: all state returns to the reset values, and the next sample is checked against red/red. Lights already green then read as a legal red->green.
- Counter saturation at 15 is not a fault. A yellow held 15+ ticks passes the timing check.

Test Plan (TICK_COUNT=4, MIN_YELLOW=3):
- Legal cycle: main red->green 10 ticks->yellow 3 ticks->red; cross red throughout; then cross green->yellow 4 ticks->red -> fault=0 throughout; tick pulses every 5 cycles.
- Conflict: main=5'b00100 and cross=5'b00100 in the same cycle -> next cycle fault=1, fault_code=3. A later main=5'b11000 leaves the code at 3.
- Short yellow: main green->yellow held 2 ticks->red -> fault_code=6 one cycle after red is sampled. Assert clear with legal lights -> fault=0, fault_code=0 next cycle.
- Skipped yellow, with simultaneous events:
  - main_arrow 5'b00001->5'b10000 directly -> fault_code=4.
  - After clear: cross=5'b00000 and main=5'b00100 in the same cycle -> fault_code=2 (no transition check on cross).
- Clear/violation collision: a held fault code 3 with clear=1 and a new yellow->green on cross in the same cycle -> fault stays 1, fault_code=5.
- Async reset: drop rst mid-yellow, asynchronously to clk -> fault, fault_code and tick go 0 immediately. After release, main=green -> no fault (red->green legal).

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// Lights bus between the traffic FSM and its independent monitor.
// The FSM side (master) drives the lights and clear; the monitor (slave) reports fault status and the tick.
interface traffic_light_monitor_if;
  logic [4:0] main_lights;
  logic [4:0] cross_lights;
  logic       clear;
  logic       fault;
  logic [3:0] fault_code;
  logic       tick;

  modport master (
    output main_lights, cross_lights, clear,
    input  fault, fault_code, tick
  );

  modport slave (
    input  main_lights, cross_lights, clear,
    output fault, fault_code, tick
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Independent checker for the traffic-light outputs: one-hot, conflict, transition and
// minimum-yellow rules, with a sticky first-fault code and a 1 s tick prescaler.
module traffic_light_monitor #(
  parameter int unsigned TICK_COUNT = 49999999,
  parameter int unsigned MIN_YELLOW = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_light_monitor_if.slave  lights
);

  localparam int unsigned PW = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
  localparam logic [PW-1:0] TICK_RELOAD = PW'(TICK_COUNT);

  // Light encoding {red, yellow, green, yellow_arrow, green_arrow}.
  localparam logic [4:0] L_RED    = 5'b10000;
  localparam logic [4:0] L_YELLOW = 5'b01000;
  localparam logic [4:0] L_GREEN  = 5'b00100;
  localparam logic [4:0] L_YARROW = 5'b00010;
  localparam logic [4:0] L_GARROW = 5'b00001;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [4:0]    prev_main_q, prev_main_d;
  logic [4:0]    prev_cross_q, prev_cross_d;
  logic [3:0]    ycnt_main_q, ycnt_main_d;
  logic [3:0]    ycnt_cross_q, ycnt_cross_d;
  logic          fault_q, fault_d;
  logic [3:0]    code_q, code_d;

  logic [7:1]    viol;
  logic [3:0]    lowest_code;
  logic          main_ok, cross_ok, prev_main_ok, prev_cross_ok;

  function automatic logic is_yellow(input logic [4:0] l);
    return (l == L_YELLOW) || (l == L_YARROW);
  endfunction

  // Caller guarantees both values are one-hot.
  function automatic logic legal_step(input logic [4:0] prev, input logic [4:0] cur);
    logic ok;
    ok = (prev == cur);
    case (prev)
      L_RED:    ok = ok || (cur == L_GREEN) || (cur == L_GARROW);
      L_GREEN:  ok = ok || (cur == L_YELLOW);
      L_YELLOW: ok = ok || (cur == L_RED);
      L_GARROW: ok = ok || (cur == L_YARROW);
      L_YARROW: ok = ok || (cur == L_RED);
      default:  ok = ok;
    endcase
    return ok;
  endfunction

  function automatic logic short_yellow(input logic [4:0] prev, input logic [4:0] cur,
                                        input logic [3:0] cnt);
    return is_yellow(prev) && (cur == L_RED) && (32'(cnt) < MIN_YELLOW);
  endfunction

  // Counter restarts on yellow entry, then counts ticks while yellow, saturating at 15.
  function automatic logic [3:0] ycnt_next(input logic [4:0] prev, input logic [4:0] cur,
                                           input logic [3:0] cnt, input logic tk);
    logic [3:0] n;
    n = cnt;
    if (is_yellow(cur) && (cur != prev))
      n = 4'd0;
    else if (is_yellow(cur) && tk && (cnt != 4'hF))
      n = cnt + 4'd1;
    return n;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    viol        = '0;
    lowest_code = 4'd0;

    main_ok       = $onehot(lights.main_lights);
    cross_ok      = $onehot(lights.cross_lights);
    prev_main_ok  = $onehot(prev_main_q);
    prev_cross_ok = $onehot(prev_cross_q);

    viol[1] = !main_ok;
    viol[2] = !cross_ok;
    viol[3] = !lights.main_lights[4] && !lights.cross_lights[4];
    viol[4] = main_ok && prev_main_ok && !legal_step(prev_main_q, lights.main_lights);
    viol[5] = cross_ok && prev_cross_ok && !legal_step(prev_cross_q, lights.cross_lights);
    viol[6] = main_ok && prev_main_ok &&
              short_yellow(prev_main_q, lights.main_lights, ycnt_main_q);
    viol[7] = cross_ok && prev_cross_ok &&
              short_yellow(prev_cross_q, lights.cross_lights, ycnt_cross_q);

    for (int i = 7; i >= 1; i--)
      if (viol[i]) lowest_code = 4'(i);
  end

  always_comb begin
    if (presc_q == '0) begin
      presc_d = TICK_RELOAD;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q - 1'b1;
      tick_d  = 1'b0;
    end

    prev_main_d  = lights.main_lights;
    prev_cross_d = lights.cross_lights;
    ycnt_main_d  = ycnt_next(prev_main_q, lights.main_lights, ycnt_main_q, tick_q);
    ycnt_cross_d = ycnt_next(prev_cross_q, lights.cross_lights, ycnt_cross_q, tick_q);

    fault_d = fault_q;
    code_d  = code_q;
    // A violation coinciding with clear wins, so a clear can never hide a fresh fault.
    if ((!fault_q || lights.clear) && (viol != '0)) begin
      fault_d = 1'b1;
      code_d  = lowest_code;
    end else if (lights.clear) begin
      fault_d = 1'b0;
      code_d  = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= TICK_RELOAD;
      tick_q       <= 1'b0;
      prev_main_q  <= L_RED;
      prev_cross_q <= L_RED;
      ycnt_main_q  <= 4'd0;
      ycnt_cross_q <= 4'd0;
      fault_q      <= 1'b0;
      code_q       <= 4'd0;
    end else begin
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      prev_main_q  <= prev_main_d;
      prev_cross_q <= prev_cross_d;
      ycnt_main_q  <= ycnt_main_d;
      ycnt_cross_q <= ycnt_cross_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
    end
  end

  assign lights.fault      = fault_q;
  assign lights.fault_code = code_q;
  assign lights.tick       = tick_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed vector table, async-reset
// sequence, and randomized traffic checked against a rule-level reference model.
module tb_traffic_light_monitor;

  localparam int unsigned TICK = 4;
  localparam int unsigned MINY = 3;
  localparam int          PERIOD = TICK + 1;

  localparam logic [4:0] R  = 5'b10000;
  localparam logic [4:0] Y  = 5'b01000;
  localparam logic [4:0] G  = 5'b00100;
  localparam logic [4:0] YA = 5'b00010;
  localparam logic [4:0] GA = 5'b00001;

  logic clk;
  logic rst;
  traffic_light_monitor_if bus ();

  traffic_light_monitor #(.TICK_COUNT(TICK), .MIN_YELLOW(MINY)) dut (
    .clk    (clk),
    .rst    (rst),
    .lights (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0] m_prev_main, m_prev_cross;
  int         m_yt_main, m_yt_cross;
  int         m_cyc;
  logic       m_fault;
  logic [3:0] m_code;

  typedef struct { logic [4:0] from; logic [4:0] to; } pair_t;
  pair_t legal_pairs [6];

  function automatic bit onehot(input logic [4:0] l);
    return $countones(l) == 1;
  endfunction

  function automatic bit yel(input logic [4:0] l);
    return (l == Y) || (l == YA);
  endfunction

  function automatic bit allowed(input logic [4:0] a, input logic [4:0] b);
    if (a == b) return 1'b1;
    foreach (legal_pairs[i])
      if (legal_pairs[i].from == a && legal_pairs[i].to == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_prev_main  = R;
    m_prev_cross = R;
    m_yt_main    = 0;
    m_yt_cross   = 0;
    m_cyc        = 0;
    m_fault      = 1'b0;
    m_code       = 4'd0;
  endtask

  // Evaluate one clock edge with the given sampled lights.
  task automatic model_edge(input logic [4:0] mn, input logic [4:0] cr, input logic clr);
    bit v [1:7];
    int first;
    bit tick_now;
    tick_now = (m_cyc != 0) && (m_cyc % PERIOD == 0);
    v[1] = !onehot(mn);
    v[2] = !onehot(cr);
    v[3] = (mn[4] == 1'b0) && (cr[4] == 1'b0);
    v[4] = onehot(mn) && onehot(m_prev_main)  && !allowed(m_prev_main, mn);
    v[5] = onehot(cr) && onehot(m_prev_cross) && !allowed(m_prev_cross, cr);
    v[6] = onehot(mn) && onehot(m_prev_main)  && yel(m_prev_main)  && mn == R && m_yt_main  < MINY;
    v[7] = onehot(cr) && onehot(m_prev_cross) && yel(m_prev_cross) && cr == R && m_yt_cross < MINY;
    first = 0;
    for (int i = 7; i >= 1; i--) if (v[i]) first = i;

    if ((!m_fault || clr) && first != 0) begin
      m_fault = 1'b1;
      m_code  = 4'(first);
    end else if (clr) begin
      m_fault = 1'b0;
      m_code  = 4'd0;
    end

    if (yel(mn) && mn != m_prev_main) m_yt_main = 0;
    else if (yel(mn) && tick_now)     m_yt_main++;
    if (yel(cr) && cr != m_prev_cross) m_yt_cross = 0;
    else if (yel(cr) && tick_now)      m_yt_cross++;

    m_prev_main  = mn;
    m_prev_cross = cr;
    m_cyc++;
  endtask

  // Apply one cycle at the negedge, advance, and compare the DUT with the model.
  task automatic step(input logic [4:0] mn, input logic [4:0] cr, input logic clr);
    bus.main_lights  = mn;
    bus.cross_lights = cr;
    bus.clear        = clr;
    model_edge(mn, cr, clr);
    @(posedge clk);
    @(negedge clk);
    check("model_fault", 32'(bus.fault), 32'(m_fault));
    check("model_code",  32'(bus.fault_code), 32'(m_code));
    check("model_tick",  32'(bus.tick), 32'((m_cyc % PERIOD) == 0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0] mn;
    logic [4:0] cr;
    logic       clr;
    int         cycles;
    logic       exp_fault;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs [24];

  function automatic logic [4:0] next_legal(input logic [4:0] p);
    case (p)
      R:       return ($urandom_range(0, 1) == 0) ? G : GA;
      G:       return Y;
      GA:      return YA;
      default: return R;
    endcase
  endfunction

  function automatic logic [4:0] pick(input logic [4:0] p);
    int r;
    r = $urandom_range(0, 99);
    if (r < 75)      return p;
    else if (r < 93) return next_legal(p);
    else             return 5'($urandom);
  endfunction

  initial begin
    legal_pairs[0] = '{R, G};
    legal_pairs[1] = '{R, GA};
    legal_pairs[2] = '{G, Y};
    legal_pairs[3] = '{Y, R};
    legal_pairs[4] = '{GA, YA};
    legal_pairs[5] = '{YA, R};

    vecs[0]  = '{R, R, 1'b0, 3,  1'b0, 4'd0};
    vecs[1]  = '{G, R, 1'b0, 50, 1'b0, 4'd0};   // 10 ticks green
    vecs[2]  = '{Y, R, 1'b0, 16, 1'b0, 4'd0};   // 3 ticks yellow
    vecs[3]  = '{R, R, 1'b0, 2,  1'b0, 4'd0};
    vecs[4]  = '{R, G, 1'b0, 5,  1'b0, 4'd0};
    vecs[5]  = '{R, Y, 1'b0, 21, 1'b0, 4'd0};   // 4 ticks yellow
    vecs[6]  = '{R, R, 1'b0, 2,  1'b0, 4'd0};
    vecs[7]  = '{G, G, 1'b0, 1,  1'b1, 4'd3};   // conflict
    vecs[8]  = '{5'b11000, G, 1'b0, 1, 1'b1, 4'd3};
    vecs[9]  = '{R, Y, 1'b1, 16, 1'b0, 4'd0};   // clear, legal lights
    vecs[10] = '{R, R, 1'b0, 2,  1'b0, 4'd0};
    vecs[11] = '{G, R, 1'b0, 10, 1'b0, 4'd0};
    vecs[12] = '{Y, R, 1'b0, 11, 1'b0, 4'd0};   // only 2 ticks yellow
    vecs[13] = '{R, R, 1'b0, 1,  1'b1, 4'd6};
    vecs[14] = '{R, R, 1'b1, 1,  1'b0, 4'd0};
    vecs[15] = '{GA, R, 1'b0, 3, 1'b0, 4'd0};
    vecs[16] = '{R, R, 1'b0, 1,  1'b1, 4'd4};   // skipped yellow arrow
    vecs[17] = '{R, R, 1'b1, 1,  1'b0, 4'd0};
    vecs[18] = '{G, 5'b00000, 1'b0, 1, 1'b1, 4'd2};
    vecs[19] = '{G, R, 1'b1, 1,  1'b0, 4'd0};
    vecs[20] = '{G, Y, 1'b0, 1,  1'b1, 4'd3};
    vecs[21] = '{Y, Y, 1'b0, 1,  1'b1, 4'd3};
    vecs[22] = '{R, Y, 1'b0, 1,  1'b1, 4'd3};   // short yellow ignored while held
    vecs[23] = '{R, G, 1'b1, 1,  1'b1, 4'd5};   // clear collides with yellow->green

    // Reset state
    rst              = 1'b0;
    bus.main_lights  = R;
    bus.cross_lights = R;
    bus.clear        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_fault", 32'(bus.fault), 32'd0);
    check("reset_code",  32'(bus.fault_code), 32'd0);
    check("reset_tick",  32'(bus.tick), 32'd0);
    rst = 1'b1;

    // Table
    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++)
        step(vecs[i].mn, vecs[i].cr, vecs[i].clr);
      check($sformatf("vec%0d_fault", i), 32'(bus.fault), 32'(vecs[i].exp_fault));
      check($sformatf("vec%0d_code", i),  32'(bus.fault_code), 32'(vecs[i].exp_code));
    end

    // Async reset mid-yellow while a fault is held
    repeat (3) step(R, Y, 1'b0);
    check("pre_reset_fault", 32'(bus.fault), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("async_fault", 32'(bus.fault), 32'd0);
    check("async_code",  32'(bus.fault_code), 32'd0);
    check("async_tick",  32'(bus.tick), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 12; c++) step(G, R, 1'b0);
    check("post_reset_fault", 32'(bus.fault), 32'd0);
    check("post_reset_code",  32'(bus.fault_code), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] mn;
      logic [4:0] cr;
      mn = pick(m_prev_main);
      cr = pick(m_prev_cross);
      step(mn, cr, ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
